master_bus_arbiter: RTL and testbench

//  Sequential two-master arbiter for the shared 30-bit word-addressed memory bus.

---
 rtl/master_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_master_bus_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/master_bus_arbiter.sv
// ---------------------------------------------------------------------------
// master_bus_arbiter
//   Sequential two-master arbiter for the shared 30-bit word-addressed memory
//   bus. Master A is instruction fetch and master B is load/store. One master
//   is granted per transaction. The grant is held until the slave signals
//   completion or the timeout expires. Each master gets its own 1-cycle
//   ack or error pulse.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   - round-robin between A and B when both request in IDLE
//                 (lastA register, reset 0, so A is granted first)
//     undefined - fixed priority, A always wins when reqA=1
//
// Parameters
//   TIMEOUT_CYCLES  grant cycles before abort; 0 disables the timeout
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   reqA      in   master A request, held until ackA/errA
//   reqB      in   master B request, held until ackB/errB
//   ackA      out  1-cycle pulse, A transaction completed
//   ackB      out  1-cycle pulse, B transaction completed
//   errA      out  1-cycle pulse, A transaction timed out
//   errB      out  1-cycle pulse, B transaction timed out
//   useA      out  bus mux select, 1 = master A owns the bus (reset 1)
//   busValid  out  transaction strobe, high for the whole grant
//   busDone   in   slave completion pulse for the current transaction
//
// Handshake: a master raises req and keeps it high. The grant state is
// entered on the next edge, and busValid/useA are registered from that edge.
// The transaction ends in the cycle where busDone=1 (ack) or where the
// timeout expires (err). The ack/err pulse is combinational in that same
// cycle. The next cycle is always IDLE.
// ---------------------------------------------------------------------------
module master_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic reqA,
  input  logic reqB,
  output logic ackA,
  output logic ackB,
  output logic errA,
  output logic errB,
  output logic useA,
  output logic busValid,
  input  logic busDone
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  // The counter needs at least one bit, even when the timeout is disabled.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] EXP_VAL =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             expire;
  logic             pickA;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastA;

  // On contention, grant the master not served last.
  always_comb begin
    pickA = reqA && (!reqB || !lastA);
  end
`else
  always_comb begin
    pickA = reqA;
  end
`endif

  // Expiry is flagged in the grant cycle whose count is TIMEOUT_CYCLES-1.
  // With the count cleared on entry, that is grant cycle TIMEOUT_CYCLES.
  always_comb begin
    expire = TO_EN && (cnt == EXP_VAL);
  end

  // Pulses are decoded from the state. When busDone and expiry coincide,
  // busDone wins. All pulses are masked in the reset cycle.
  always_comb begin
    ackA = !rst && (state == GRANT_A) && busDone;
    ackB = !rst && (state == GRANT_B) && busDone;
    errA = !rst && (state == GRANT_A) && !busDone && expire;
    errB = !rst && (state == GRANT_B) && !busDone && expire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busValid <= 1'b0;
      useA     <= 1'b1;
      cnt      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      lastA    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // useA keeps its last value here so the mux path stays stable.
          if (reqA || reqB) begin
            state    <= pickA ? GRANT_A : GRANT_B;
            useA     <= pickA;
            busValid <= 1'b1;
            cnt      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            lastA    <= pickA;
`endif
          end
        end
        GRANT_A, GRANT_B: begin
          // Request drops during a grant are ignored. Only done or expiry
          // ends the transaction.
          if (busDone || expire) begin
            state    <= IDLE;
            busValid <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          busValid <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_master_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_master_bus_arbiter
//   Directed scenarios for master_bus_arbiter with TIMEOUT_CYCLES=4.
//   A negedge monitor pops the expected ack/err pulse, as a one-hot value
//   {errB,errA,ackB,ackA}, from exp_q whenever any pulse is seen. A pulse
//   with nothing queued is an error. Grant order under contention follows
//   ARB_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_master_bus_arbiter;

  localparam int TO = 4;

  localparam logic [3:0] EV_ACKA = 4'b0001;
  localparam logic [3:0] EV_ACKB = 4'b0010;
  localparam logic [3:0] EV_ERRB = 4'b1000;

  logic clk = 1'b0;
  logic rst, reqA, reqB, busDone;
  logic ackA, ackB, errA, errB, useA, busValid;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];

  master_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .reqA(reqA), .reqB(reqB),
    .ackA(ackA), .ackB(ackB), .errA(errA), .errB(errB),
    .useA(useA), .busValid(busValid), .busDone(busDone)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Advance to the next cycle. Inputs are driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [3:0] obs;
    logic [3:0] exp_v;
    obs = {errB, errA, ackB, ackA};
    if (obs != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: got %b required none at %0t", obs, $time);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL pulse: got %b required %b at %0t", obs, exp_v, $time);
        end
      end
    end
  end

  // Check busValid and useA at the negedge of the current cycle.
  task automatic check_bus(input string name, input logic expV, input logic expU);
    @(negedge clk);
    checks++;
    if (busValid !== expV || useA !== expU) begin
      errors++;
      $display("FAIL %s: got busValid=%b useA=%b required busValid=%b useA=%b",
               name, busValid, useA, expV, expU);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; reqA = 1'b0; reqB = 1'b0; busDone = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    // Reset was released this cycle. State is still the reset state.
    check_bus("reset_state", 1'b0, 1'b1);
    tick();
    busDone = 1'b1;  // busDone in IDLE must not produce an ack
    check_bus("idle_busdone_ignored", 1'b0, 1'b1);
    tick();
    busDone = 1'b0;
  endtask

  task automatic test_single_a();
    do_reset();
    reqA = 1'b1;                               // cycle 0
    check_bus("single_a_c0", 1'b0, 1'b1);
    tick(); check_bus("single_a_c1", 1'b1, 1'b1);
    tick(); check_bus("single_a_c2", 1'b1, 1'b1);
    tick(); busDone = 1'b1; exp_q.push_back(EV_ACKA);
    check_bus("single_a_c3", 1'b1, 1'b1);
    tick(); busDone = 1'b0; reqA = 1'b0;
    check_bus("single_a_c4", 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_b_only();
    do_reset();
    reqB = 1'b1;                               // cycle 0
    tick(); busDone = 1'b1; exp_q.push_back(EV_ACKB);
    check_bus("b_only_c1", 1'b1, 1'b0);
    tick(); busDone = 1'b0; reqB = 1'b0;
    check_bus("b_only_idle_hold", 1'b0, 1'b0);
    tick(); check_bus("b_only_idle_hold2", 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_contention();
    int n;
    logic expU;
    do_reset();
    reqA = 1'b1; reqB = 1'b1;
    for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
      expU = (t % 2 == 0);
`else
      expU = 1'b1;
`endif
      n = 0;
      @(negedge clk);
      while (!busValid && n < 10) begin
        tick();
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 10) begin
        errors++;
        $display("FAIL contention_wait: got no busValid required grant %0d", t);
      end else if (useA !== expU) begin
        errors++;
        $display("FAIL contention_grant%0d: got useA=%b required %b", t, useA, expU);
      end
      tick();
      busDone = 1'b1;
      exp_q.push_back(expU ? EV_ACKA : EV_ACKB);
      tick();
      busDone = 1'b0;
    end
    reqA = 1'b0; reqB = 1'b0;                  // in the IDLE bubble
    tick(); tick();
  endtask

  task automatic test_timeout();
    do_reset();
    reqB = 1'b1;
    for (int c = 1; c <= TO; c++) begin
      tick();
      if (c == TO) exp_q.push_back(EV_ERRB);
      check_bus($sformatf("timeout_c%0d", c), 1'b1, 1'b0);
    end
    tick(); check_bus("timeout_idle", 1'b0, 1'b0);
    tick(); check_bus("timeout_regrant", 1'b1, 1'b0);
    rst = 1'b1; reqB = 1'b0;
    tick(); rst = 1'b0;
    tick();
  endtask

  task automatic test_done_on_expiry();
    do_reset();
    reqB = 1'b1;
    for (int c = 1; c <= TO; c++) begin
      tick();
      if (c == TO) begin
        busDone = 1'b1;
        exp_q.push_back(EV_ACKB);
      end
      check_bus($sformatf("expiry_c%0d", c), 1'b1, 1'b0);
    end
    tick(); busDone = 1'b0; reqB = 1'b0;
    check_bus("expiry_idle", 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    reqB = 1'b1;
    tick(); check_bus("midrst_c1", 1'b1, 1'b0);
    tick(); rst = 1'b1; busDone = 1'b1;        // ack must be suppressed
    tick(); rst = 1'b0; busDone = 1'b0; reqB = 1'b0;
    check_bus("midrst_after", 1'b0, 1'b1);
    for (int c = 0; c < TO + 2; c++) begin
      tick(); check_bus("midrst_quiet", 1'b0, 1'b1);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    rst = 1'b1; reqA = 1'b0; reqB = 1'b0; busDone = 1'b0;
    test_reset();
    test_single_a();
    test_b_only();
    test_contention();
    test_timeout();
    test_done_on_expiry();
    test_reset_mid_grant();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pulses_missing: got %0d left in queue required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish required finish before limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
